// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with memory-wait, mul/div-wait and halt
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             ihz_stall_fetch,
    input  logic             ihz_stall_decod,
    input  logic             ihz_flush_decod,
    input  logic             ihz_flush_exect,
    input  logic             imd_valid_exect,
    input  logic             imd_done,
    input  logic             imem_req,
    input  logic             imem_ack,
    output logic             ostall_fetch,
    output logic             ostall_decod,
    output logic             ostall_exect,
    output logic             ostall_mem,
    output logic             oflush_decod,
    output logic             oflush_exect,
    output logic             oflush_mem,
    output logic             oflush_wrt,
    output logic             omd_start,
    output logic [1:0]       ostate,
    output logic             ohalt,
    output logic [CNT_W-1:0] ostall_cycles
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_MEM_WAIT = 2'b01,
        S_MD_WAIT  = 2'b10,
        S_HALT     = 2'b11
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       memwait;

    assign memwait = imem_req & ~imem_ack;
    assign ostate  = state;
    assign ohalt   = (state == S_HALT);

    // Outputs are gated by irst_n so they read 0 for the whole reset window.
    always_comb begin
        ostall_fetch = 1'b0;
        ostall_decod = 1'b0;
        ostall_exect = 1'b0;
        ostall_mem   = 1'b0;
        oflush_decod = 1'b0;
        oflush_exect = 1'b0;
        oflush_mem   = 1'b0;
        oflush_wrt   = 1'b0;
        omd_start    = 1'b0;
        if (irst_n) begin
            unique case (state)
                S_RUN, S_MEM_WAIT: begin
                    if ((state == S_RUN) ? memwait : ~imem_ack) begin
                        {ostall_fetch, ostall_decod, ostall_exect, ostall_mem} = 4'b1111;
                        oflush_wrt = 1'b1;
                    end else if (state == S_RUN && imd_valid_exect) begin
                        omd_start = 1'b1;
                        {ostall_fetch, ostall_decod, ostall_exect} = 3'b111;
                        oflush_mem = 1'b1;
                    end else begin
                        ostall_fetch = ihz_stall_fetch;
                        ostall_decod = ihz_stall_decod;
                        oflush_decod = ihz_flush_decod;
                        oflush_exect = ihz_flush_exect;
                    end
                end
                S_MD_WAIT: begin
                    if (!imd_done) begin
                        {ostall_fetch, ostall_decod, ostall_exect} = 3'b111;
                        oflush_mem = 1'b1;
                    end
                end
                S_HALT: begin
                    {ostall_fetch, ostall_decod, ostall_exect, ostall_mem} = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    // wait_cnt counts consecutive unacked cycles, including the one spent in RUN.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state    <= S_RUN;
            wait_cnt <= 8'd0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (memwait) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end else if (imd_valid_exect) begin
                        state <= S_MD_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (imem_ack) begin
                        state    <= S_RUN;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt >= 8'(MEM_TIMEOUT - 1))
                            state <= S_HALT;
                    end
                end
                S_MD_WAIT: begin
                    if (imd_done)
                        state <= S_RUN;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)
            ostall_cycles <= '0;
        else if (ostall_fetch && (ostall_cycles != {CNT_W{1'b1}}))
            ostall_cycles <= ostall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and random checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    localparam int TO = 4;
    localparam int CW = 6;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          ihz_stall_fetch = 0, ihz_stall_decod = 0, ihz_flush_decod = 0, ihz_flush_exect = 0;
    logic          imd_valid_exect = 0, imd_done = 0, imem_req = 0, imem_ack = 0;
    logic          ostall_fetch, ostall_decod, ostall_exect, ostall_mem;
    logic          oflush_decod, oflush_exect, oflush_mem, oflush_wrt, omd_start;
    logic [1:0]    ostate;
    logic          ohalt;
    logic [CW-1:0] ostall_cycles;

    int total = 0;
    int bad   = 0;

    // Model: halted flag, mul/div busy flag, length of current unacked memory run.
    bit m_halt, m_md;
    int m_run, m_cnt;

    pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .iclk(iclk), .irst_n(irst_n),
        .ihz_stall_fetch(ihz_stall_fetch), .ihz_stall_decod(ihz_stall_decod),
        .ihz_flush_decod(ihz_flush_decod), .ihz_flush_exect(ihz_flush_exect),
        .imd_valid_exect(imd_valid_exect), .imd_done(imd_done),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .ostall_fetch(ostall_fetch), .ostall_decod(ostall_decod),
        .ostall_exect(ostall_exect), .ostall_mem(ostall_mem),
        .oflush_decod(oflush_decod), .oflush_exect(oflush_exect),
        .oflush_mem(oflush_mem), .oflush_wrt(oflush_wrt), .omd_start(omd_start),
        .ostate(ostate), .ohalt(ohalt), .ostall_cycles(ostall_cycles)
    );

    always #5 iclk = ~iclk;

    // Bit order: stall f,d,e,m | flush d,e,m,w | md_start
    function automatic logic [8:0] exp_out();
        logic [8:0] pass;
        pass = {ihz_stall_fetch, ihz_stall_decod, 2'b00, ihz_flush_decod, ihz_flush_exect, 3'b000};
        if (m_halt)      return 9'b1111_0000_0;
        if (m_md)        return imd_done ? 9'b0 : 9'b1110_0010_0;
        if (m_run > 0)   return imem_ack ? pass : 9'b1111_0001_0;
        if (imem_req && !imem_ack) return 9'b1111_0001_0;
        if (imd_valid_exect)       return 9'b1110_0010_1;
        return pass;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_halt) return 2'b11;
        if (m_md)   return 2'b10;
        if (m_run > 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [8:0] obs_out();
        return {ostall_fetch, ostall_decod, ostall_exect, ostall_mem,
                oflush_decod, oflush_exect, oflush_mem, oflush_wrt, omd_start};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [8:0] e;
        e = exp_out();
        if (e[8]) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
        if (m_halt) return;
        if (m_md) begin
            if (imd_done) m_md = 0;
        end else if (m_run > 0) begin
            if (imem_ack) m_run = 0;
            else begin
                m_run++;
                if (m_run >= TO) m_halt = 1;
            end
        end else if (imem_req && !imem_ack) begin
            m_run = 1;
        end else if (imd_valid_exect) begin
            m_md = 1;
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge iclk);
        chk({tag, ":out"}, 16'(obs_out()), 16'(exp_out()));
        chk({tag, ":state"}, 16'(ostate), 16'(exp_state()));
        chk({tag, ":halt"}, 16'(ohalt), 16'(m_halt));
        chk({tag, ":cnt"}, 16'(ostall_cycles), 16'(m_cnt));
        @(posedge iclk);
        model_step();
        #1;
    endtask

    task automatic drive(input string tag, input logic [7:0] v);
        {ihz_stall_fetch, ihz_stall_decod, ihz_flush_decod, ihz_flush_exect,
         imd_valid_exect, imd_done, imem_req, imem_ack} = v;
        cycle(tag);
    endtask

    // Reset asserted mid-cycle with busy inputs; checked at once and across an edge.
    task automatic do_reset(input string tag);
        @(negedge iclk);
        #2;
        {ihz_stall_fetch, ihz_stall_decod, ihz_flush_decod, ihz_flush_exect,
         imd_valid_exect, imd_done, imem_req, imem_ack} = 8'hFF;
        irst_n = 1'b0;
        #1;
        chk({tag, ":rst_state"}, 16'(ostate), 16'd0);
        chk({tag, ":rst_cnt"}, 16'(ostall_cycles), 16'd0);
        chk({tag, ":rst_halt"}, 16'(ohalt), 16'd0);
        chk({tag, ":rst_out"}, 16'(obs_out()), 16'd0);
        @(posedge iclk);
        #1;
        chk({tag, ":rst_out_edge"}, 16'(obs_out()), 16'd0);
        {ihz_stall_fetch, ihz_stall_decod, ihz_flush_decod, ihz_flush_exect,
         imd_valid_exect, imd_done, imem_req, imem_ack} = 8'h00;
        @(negedge iclk);
        irst_n = 1'b1;
        m_halt = 0; m_md = 0; m_run = 0; m_cnt = 0;
        @(posedge iclk);
        #1;
    endtask

    initial begin
        m_halt = 0; m_md = 0; m_run = 0; m_cnt = 0;
        do_reset("init");

        drive("hz", 8'b1001_0000);
        drive("hz2", 8'b1111_0000);
        drive("idle", 8'b0000_0000);

        do_reset("r34");
        drive("mem1", 8'b0000_0010);
        drive("mem2", 8'b0000_0010);
        drive("mem3", 8'b0000_0011);
        drive("mem4", 8'b0000_0000);
        chk("mem_cycles", 16'(ostall_cycles), 16'd2);

        do_reset("r35");
        drive("md1", 8'b0000_1000);
        drive("md2", 8'b1111_1000);
        drive("md3", 8'b0000_1010);
        drive("md4", 8'b0000_1000);
        drive("md5", 8'b0000_1100);
        drive("md6", 8'b0000_0000);

        do_reset("r36");
        for (int i = 0; i < 6; i++) drive("to", 8'b1111_1010);
        chk("to_state", 16'(ostate), 16'd3);
        chk("to_halt", 16'(ohalt), 16'd1);
        do_reset("halt");

        drive("both1", 8'b0000_1010);
        drive("both2", 8'b0000_1011);
        drive("both3", 8'b0000_1000);
        drive("both4", 8'b0000_0100);

        drive("mdr1", 8'b0000_1000);
        drive("mdr2", 8'b0000_0010);
        do_reset("mdrst");

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            ihz_stall_fetch = 1'($urandom);
            ihz_stall_decod = 1'($urandom);
            ihz_flush_decod = 1'($urandom);
            ihz_flush_exect = 1'($urandom);
            imd_valid_exect = ($urandom_range(0, 3) == 0);
            imd_done        = ($urandom_range(0, 2) == 0);
            imem_req        = ($urandom_range(0, 2) == 0);
            imem_ack        = 1'($urandom);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
